// File: rtl/flow_capture_buffer_if.sv
// ---------------------------------------------------------------------------
// flow_capture_buffer_if
// Bus bundle between the flow producer / host and flow_capture_buffer.
//   Flow stream (producer -> buffer):
//     flow_x, flow_y    pixel coordinate of the beat
//     flow_u, flow_v    signed flow components
//     flow_valid        beat qualifier, no backpressure
//     frame_done        1-cycle end-of-frame pulse
//   Map read port (host <-> buffer):
//     rd_en, rd_addr    read request, address = y*IMAGE_WIDTH + x
//     rd_data, rd_valid {u, v} returned one cycle after the request
// master = producer/host side, slave = flow_capture_buffer side.
// ---------------------------------------------------------------------------
interface flow_capture_buffer_if #(
    parameter int FLOW_WIDTH = 16
);
    logic        [9:0]              flow_x;
    logic        [8:0]              flow_y;
    logic signed [FLOW_WIDTH-1:0]   flow_u;
    logic signed [FLOW_WIDTH-1:0]   flow_v;
    logic                           flow_valid;
    logic                           frame_done;
    logic                           rd_en;
    logic        [16:0]             rd_addr;
    logic        [2*FLOW_WIDTH-1:0] rd_data;
    logic                           rd_valid;

    modport master (
        output flow_x, flow_y, flow_u, flow_v, flow_valid, frame_done,
        output rd_en, rd_addr,
        input  rd_data, rd_valid
    );

    modport slave (
        input  flow_x, flow_y, flow_u, flow_v, flow_valid, frame_done,
        input  rd_en, rd_addr,
        output rd_data, rd_valid
    );
endinterface

// File: rtl/flow_capture_buffer.sv
// ---------------------------------------------------------------------------
// flow_capture_buffer
// Captures the optical-flow accelerator's vector stream into a frame-sized
// map of {u, v} words, keeps per-frame statistics, and serves map reads.
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset (map contents are kept)
//   arm           1-cycle pulse: clear the map, then capture the next frame
//   bus           flow stream + read port (flow_capture_buffer_if.slave)
//   capture_busy  high while clearing, armed, or capturing
//   capture_done  1-cycle pulse when a frame has been closed
//   vec_count     vectors stored this frame (saturating)
//   moving_count  stored vectors with |u|+|v| > MAG_THRESH (saturating)
//   sum_u, sum_v  wrapping sums of the stored components
//   coord_err     sticky: out-of-range coordinate seen while accepting
//   drop_err      sticky: beat arrived while not accepting
// ---------------------------------------------------------------------------
module flow_capture_buffer #(
    parameter int IMAGE_WIDTH  = 320,
    parameter int IMAGE_HEIGHT = 240,
    parameter int FLOW_WIDTH   = 16,
    parameter int MAG_THRESH   = 128
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       arm,
    flow_capture_buffer_if.slave       bus,
    output logic                       capture_busy,
    output logic                       capture_done,
    output logic        [16:0]         vec_count,
    output logic        [16:0]         moving_count,
    output logic signed [31:0]         sum_u,
    output logic signed [31:0]         sum_v,
    output logic                       coord_err,
    output logic                       drop_err
);
    localparam int DEPTH  = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FW     = FLOW_WIDTH;
    localparam int L1_W   = FLOW_WIDTH + 1;
    localparam int WORD_W = 2 * FLOW_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_ARMED   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // Magnitude of a two's complement component; -2^(FW-1) maps to 2^(FW-1)
    // which still fits as an unsigned FW-bit value.
    function automatic logic [FW-1:0] abs_val(input logic [FW-1:0] a);
        abs_val = a[FW-1] ? (~a + FW'(1)) : a;
    endfunction

    state_t              state_r;
    logic [ADDR_W-1:0]   clr_addr_r;
    logic                capture_busy_r;
    logic                capture_done_r;
    logic [16:0]         vec_count_r;
    logic [16:0]         moving_count_r;
    logic signed [31:0]  sum_u_r;
    logic signed [31:0]  sum_v_r;
    logic                coord_err_r;
    logic                drop_err_r;
    logic [WORD_W-1:0]   rd_data_r;
    logic                rd_valid_r;
    logic [WORD_W-1:0]   mem_r [DEPTH];

    logic                in_range_s;
    logic                accepting_s;
    logic                accept_s;
    logic                coord_bad_s;
    logic                drop_s;
    logic                moving_s;
    logic [ADDR_W-1:0]   wr_addr_s;
    logic [L1_W-1:0]     l1_s;
    logic                rd_in_range_s;
    logic                mem_we_s;
    logic [ADDR_W-1:0]   mem_waddr_s;
    logic [WORD_W-1:0]   mem_wdata_s;

    // Beat classification: accept, coordinate error, or drop.
    always_comb begin
        in_range_s    = ({7'd0, bus.flow_x} < 17'(IMAGE_WIDTH)) &&
                        ({8'd0, bus.flow_y} < 17'(IMAGE_HEIGHT));
        accepting_s   = ((state_r == ST_ARMED) || (state_r == ST_CAPTURE)) && !arm;
        accept_s      = bus.flow_valid && accepting_s && in_range_s;
        coord_bad_s   = bus.flow_valid && accepting_s && !in_range_s;
        // arm clears drop_err in the same cycle, so a coincident beat is not flagged.
        drop_s        = bus.flow_valid && !arm &&
                        ((state_r == ST_IDLE) || (state_r == ST_CLEAR) || (state_r == ST_DONE));
        // Truncation is safe: the address is only used when the coordinate is in range.
        wr_addr_s     = ADDR_W'(bus.flow_y) * ADDR_W'(IMAGE_WIDTH) + ADDR_W'(bus.flow_x);
        l1_s          = {1'b0, abs_val(bus.flow_u)} + {1'b0, abs_val(bus.flow_v)};
        moving_s      = l1_s > L1_W'(MAG_THRESH);
        rd_in_range_s = bus.rd_addr < 17'(DEPTH);
    end

    // Map write port: the clear sweep owns the port while in CLEAR.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = clr_addr_r;
        mem_wdata_s = {WORD_W{1'b0}};
        if (rst) begin
            mem_we_s = 1'b0;
        end else if (state_r == ST_CLEAR) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = clr_addr_r;
            mem_wdata_s = {WORD_W{1'b0}};
        end else if (accept_s) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = wr_addr_s;
            mem_wdata_s = {bus.flow_u, bus.flow_v};
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Flow map storage; deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Capture FSM with registered busy/done outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            clr_addr_r     <= {ADDR_W{1'b0}};
            capture_busy_r <= 1'b0;
            capture_done_r <= 1'b0;
        end else begin
            capture_done_r <= 1'b0;
            if (arm) begin
                state_r        <= ST_CLEAR;
                clr_addr_r     <= {ADDR_W{1'b0}};
                capture_busy_r <= 1'b1;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        capture_busy_r <= 1'b0;
                    end
                    ST_CLEAR: begin
                        capture_busy_r <= 1'b1;
                        clr_addr_r     <= clr_addr_r + ADDR_W'(1);
                        if (clr_addr_r == ADDR_W'(DEPTH - 1)) begin
                            state_r <= ST_ARMED;
                        end
                    end
                    ST_ARMED: begin
                        if (bus.frame_done) begin
                            state_r        <= ST_DONE;
                            capture_done_r <= 1'b1;
                            capture_busy_r <= 1'b0;
                        end else if (accept_s) begin
                            state_r        <= ST_CAPTURE;
                            capture_busy_r <= 1'b1;
                        end else begin
                            capture_busy_r <= 1'b1;
                        end
                    end
                    ST_CAPTURE: begin
                        if (bus.frame_done) begin
                            state_r        <= ST_DONE;
                            capture_done_r <= 1'b1;
                            capture_busy_r <= 1'b0;
                        end else begin
                            capture_busy_r <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        capture_busy_r <= 1'b0;
                    end
                    default: begin
                        state_r        <= ST_IDLE;
                        capture_busy_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Frame statistics and sticky error flags; arm starts a fresh frame.
    always_ff @(posedge clk) begin
        if (rst || arm) begin
            vec_count_r    <= 17'd0;
            moving_count_r <= 17'd0;
            sum_u_r        <= 32'sd0;
            sum_v_r        <= 32'sd0;
            coord_err_r    <= 1'b0;
            drop_err_r     <= 1'b0;
        end else begin
            if (accept_s) begin
                if (vec_count_r != 17'h1FFFF) begin
                    vec_count_r <= vec_count_r + 17'd1;
                end
                if (moving_s && (moving_count_r != 17'h1FFFF)) begin
                    moving_count_r <= moving_count_r + 17'd1;
                end
                sum_u_r <= sum_u_r + {{(32-FW){bus.flow_u[FW-1]}}, bus.flow_u};
                sum_v_r <= sum_v_r + {{(32-FW){bus.flow_v[FW-1]}}, bus.flow_v};
            end
            if (coord_bad_s) begin
                coord_err_r <= 1'b1;
            end
            if (drop_s) begin
                drop_err_r <= 1'b1;
            end
        end
    end

    // Registered read port; reading before the write lands returns old data.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_r <= 1'b0;
            rd_data_r  <= {WORD_W{1'b0}};
        end else if (bus.rd_en && (state_r != ST_CLEAR)) begin
            rd_valid_r <= 1'b1;
            rd_data_r  <= rd_in_range_s ? mem_r[bus.rd_addr[ADDR_W-1:0]] : {WORD_W{1'b0}};
        end else begin
            rd_valid_r <= 1'b0;
        end
    end

    assign capture_busy = capture_busy_r;
    assign capture_done = capture_done_r;
    assign vec_count    = vec_count_r;
    assign moving_count = moving_count_r;
    assign sum_u        = sum_u_r;
    assign sum_v        = sum_v_r;
    assign coord_err    = coord_err_r;
    assign drop_err     = drop_err_r;
    assign bus.rd_data  = rd_data_r;
    assign bus.rd_valid = rd_valid_r;

endmodule

// File: tb/tb_flow_capture_buffer.sv
// ---------------------------------------------------------------------------
// tb_flow_capture_buffer
// Self-checking bench for flow_capture_buffer on an 8x4 frame. A small
// reference model tracks the map and statistics; expected read data is
// queued when a read is issued and popped when rd_valid returns.
// ---------------------------------------------------------------------------
module tb_flow_capture_buffer;
    localparam int W     = 8;
    localparam int H     = 4;
    localparam int FW    = 16;
    localparam int MT    = 128;
    localparam int DEPTH = W * H;

    logic clk = 1'b0;
    logic rst;
    logic arm;
    logic capture_busy, capture_done, coord_err, drop_err;
    logic [16:0] vec_count, moving_count;
    logic signed [31:0] sum_u, sum_v;

    always #5 clk = ~clk;

    flow_capture_buffer_if #(.FLOW_WIDTH(FW)) bus ();

    flow_capture_buffer #(
        .IMAGE_WIDTH (W),
        .IMAGE_HEIGHT(H),
        .FLOW_WIDTH  (FW),
        .MAG_THRESH  (MT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .arm         (arm),
        .bus         (bus),
        .capture_busy(capture_busy),
        .capture_done(capture_done),
        .vec_count   (vec_count),
        .moving_count(moving_count),
        .sum_u       (sum_u),
        .sum_v       (sum_v),
        .coord_err   (coord_err),
        .drop_err    (drop_err)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0]        model_mem [DEPTH];
    int                 m_vec;
    int                 m_mov;
    logic signed [31:0] m_su;
    logic signed [31:0] m_sv;
    logic [31:0]        exp_q [$];

    function automatic int iabs(input int a);
        return (a < 0) ? -a : a;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        arm            = 1'b0;
        bus.flow_valid = 1'b0;
        bus.frame_done = 1'b0;
        bus.flow_x     = 10'd0;
        bus.flow_y     = 9'd0;
        bus.flow_u     = 16'sd0;
        bus.flow_v     = 16'sd0;
        bus.rd_en      = 1'b0;
        bus.rd_addr    = 17'd0;
    endtask

    task automatic model_reset;
        m_vec = 0;
        m_mov = 0;
        m_su  = 32'sd0;
        m_sv  = 32'sd0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'd0;
    endtask

    // Drive one beat for a cycle; acc tells the model whether it should be stored.
    task automatic send_beat(input int x, input int y, input int u, input int v,
                             input bit fd, input bit acc);
        bus.flow_valid = 1'b1;
        bus.flow_x     = x[9:0];
        bus.flow_y     = y[8:0];
        bus.flow_u     = u[15:0];
        bus.flow_v     = v[15:0];
        bus.frame_done = fd;
        tick;
        bus.flow_valid = 1'b0;
        bus.frame_done = 1'b0;
        if (acc) begin
            model_mem[y * W + x] = {u[15:0], v[15:0]};
            m_vec++;
            m_su = m_su + u;
            m_sv = m_sv + v;
            if (iabs(u) + iabs(v) > MT) m_mov++;
        end
    endtask

    // Issue one read (back-to-back when called consecutively), queue its expectation.
    task automatic issue_read(input int addr);
        exp_q.push_back((addr < DEPTH) ? model_mem[addr] : 32'd0);
        bus.rd_en   = 1'b1;
        bus.rd_addr = addr[16:0];
        tick;
        bus.rd_en   = 1'b0;
    endtask

    task automatic arm_and_clear;
        arm = 1'b1;
        tick;
        arm = 1'b0;
        model_reset();
        repeat (DEPTH) tick;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst = 1'b1;
        repeat (3) tick;
        checks++;
        if ({capture_busy, capture_done, bus.rd_valid, coord_err, drop_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 00000",
                     {capture_busy, capture_done, bus.rd_valid, coord_err, drop_err});
        end
        checks++;
        if ({vec_count, moving_count} !== 34'd0) begin
            errors++;
            $display("FAIL reset_counts got vec=%0d mov=%0d want 0", vec_count, moving_count);
        end
        checks++;
        if ({sum_u, sum_v, bus.rd_data} !== 96'd0) begin
            errors++;
            $display("FAIL reset_sums got su=%0d sv=%0d rd=%h want 0", sum_u, sum_v, bus.rd_data);
        end
        rst = 1'b0;
        tick;
    endtask

    task automatic test_clear;
        int k;
        arm = 1'b1;
        tick;
        arm = 1'b0;
        model_reset();
        checks++;
        if (capture_busy !== 1'b1) begin
            errors++;
            $display("FAIL clear_busy got %b want 1", capture_busy);
        end
        // Hold a read request; it is ignored until the 32-cycle clear finishes.
        bus.rd_en   = 1'b1;
        bus.rd_addr = 17'd0;
        k = 0;
        while (k < 40) begin
            tick;
            if (bus.rd_valid) break;
            k++;
        end
        bus.rd_en = 1'b0;
        checks++;
        if (k !== DEPTH) begin
            errors++;
            $display("FAIL clear_len got first valid read after %0d ignored cycles want %0d", k, DEPTH);
        end
        tick;
        for (int a = 0; a <= DEPTH; a++) begin
            issue_read(a);
            checks++;
            begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (bus.rd_valid !== 1'b1 || bus.rd_data !== e) begin
                    errors++;
                    $display("FAIL clear_read addr=%0d got v=%b d=%h want v=1 d=%h",
                             a, bus.rd_valid, bus.rd_data, e);
                end
            end
        end
        checks++;
        if (capture_busy !== 1'b1) begin
            errors++;
            $display("FAIL armed_busy got %b want 1", capture_busy);
        end
    endtask

    task automatic test_stream;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                send_beat(x, y, x * 16, -(y * 16), 1'b0, 1'b1);
                if (x == 0 && y == 0) begin
                    checks++;
                    if (vec_count !== 17'd1) begin
                        errors++;
                        $display("FAIL stream_first_count got %0d want 1", vec_count);
                    end
                end
            end
        end
        bus.frame_done = 1'b1;
        tick;
        bus.frame_done = 1'b0;
        checks++;
        if ({capture_done, capture_busy} !== 2'b10) begin
            errors++;
            $display("FAIL stream_done got done=%b busy=%b want done=1 busy=0", capture_done, capture_busy);
        end
        tick;
        checks++;
        if (capture_done !== 1'b0) begin
            errors++;
            $display("FAIL stream_done_pulse got %b want 0", capture_done);
        end
        for (int a = 0; a < DEPTH; a++) begin
            issue_read(a);
            checks++;
            begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (bus.rd_valid !== 1'b1 || bus.rd_data !== e) begin
                    errors++;
                    $display("FAIL stream_read addr=%0d got v=%b d=%h want v=1 d=%h",
                             a, bus.rd_valid, bus.rd_data, e);
                end
            end
        end
        // Nonzero word followed by out-of-range addresses, which must read as 0.
        issue_read(1);
        issue_read(DEPTH);
        checks++;
        begin
            logic [31:0] e0, e1;
            e0 = exp_q.pop_front();
            e1 = exp_q.pop_front();
            if (bus.rd_valid !== 1'b1 || bus.rd_data !== e1 || e0 == e1) begin
                errors++;
                $display("FAIL oor_read got v=%b d=%h want v=1 d=%h", bus.rd_valid, bus.rd_data, e1);
            end
        end
        issue_read(131071);
        checks++;
        begin
            logic [31:0] e;
            e = exp_q.pop_front();
            if (bus.rd_valid !== 1'b1 || bus.rd_data !== e) begin
                errors++;
                $display("FAIL oor_max_read got v=%b d=%h want v=1 d=%h", bus.rd_valid, bus.rd_data, e);
            end
        end
        tick;
        checks++;
        if (bus.rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL rd_valid_pulse got %b want 0", bus.rd_valid);
        end
        checks++;
        if (vec_count !== 17'd32 || m_vec != 32) begin
            errors++;
            $display("FAIL stream_vec got %0d want 32", vec_count);
        end
        checks++;
        if (sum_u !== 32'sd1792 || sum_v !== -32'sd768) begin
            errors++;
            $display("FAIL stream_sums got su=%0d sv=%0d want su=1792 sv=-768", sum_u, sum_v);
        end
        checks++;
        if (moving_count !== 17'(m_mov)) begin
            errors++;
            $display("FAIL stream_moving got %0d want %0d", moving_count, m_mov);
        end
    endtask

    task automatic test_magnitude;
        arm_and_clear();
        send_beat(0, 0, 100, -29, 1'b0, 1'b1);
        send_beat(1, 0, 64, 64, 1'b0, 1'b1);
        checks++;
        if (moving_count !== 17'd1) begin
            errors++;
            $display("FAIL mag_thresh got %0d want 1", moving_count);
        end
        send_beat(2, 0, -32768, 0, 1'b0, 1'b1);
        send_beat(3, 0, -32768, -32768, 1'b0, 1'b1);
        checks++;
        if (moving_count !== 17'(m_mov) || vec_count !== 17'(m_vec)) begin
            errors++;
            $display("FAIL mag_extreme got mov=%0d vec=%0d want mov=%0d vec=%0d",
                     moving_count, vec_count, m_mov, m_vec);
        end
        checks++;
        if (sum_u !== m_su || sum_v !== m_sv) begin
            errors++;
            $display("FAIL mag_sums got su=%0d sv=%0d want su=%0d sv=%0d", sum_u, sum_v, m_su, m_sv);
        end
        // Duplicate coordinate with a read of the same address in the same cycle.
        exp_q.push_back(model_mem[0]);
        bus.rd_en   = 1'b1;
        bus.rd_addr = 17'd0;
        send_beat(0, 0, 5, 6, 1'b0, 1'b1);
        bus.rd_en   = 1'b0;
        checks++;
        begin
            logic [31:0] e;
            e = exp_q.pop_front();
            if (bus.rd_valid !== 1'b1 || bus.rd_data !== e) begin
                errors++;
                $display("FAIL rw_collision got v=%b d=%h want v=1 d=%h", bus.rd_valid, bus.rd_data, e);
            end
        end
        issue_read(0);
        checks++;
        begin
            logic [31:0] e;
            e = exp_q.pop_front();
            if (bus.rd_data !== e || vec_count !== 17'd5) begin
                errors++;
                $display("FAIL dup_overwrite got d=%h vec=%0d want d=%h vec=5", bus.rd_data, vec_count, e);
            end
        end
    endtask

    task automatic test_errors;
        send_beat(8, 0, 1, 1, 1'b0, 1'b0);
        checks++;
        if ({coord_err, drop_err} !== 2'b10 || vec_count !== 17'(m_vec)) begin
            errors++;
            $display("FAIL coord_x got ce=%b de=%b vec=%0d want ce=1 de=0 vec=%0d",
                     coord_err, drop_err, vec_count, m_vec);
        end
        send_beat(0, 4, 2, 2, 1'b0, 1'b0);
        issue_read(8);
        checks++;
        begin
            logic [31:0] e;
            e = exp_q.pop_front();
            if (bus.rd_data !== e || vec_count !== 17'(m_vec)) begin
                errors++;
                $display("FAIL coord_nowrite got d=%h vec=%0d want d=%h vec=%0d",
                         bus.rd_data, vec_count, e, m_vec);
            end
        end
        send_beat(5, 0, 7, -7, 1'b1, 1'b1);
        checks++;
        if (capture_done !== 1'b1 || vec_count !== 17'(m_vec)) begin
            errors++;
            $display("FAIL done_with_beat got done=%b vec=%0d want done=1 vec=%0d",
                     capture_done, vec_count, m_vec);
        end
        send_beat(6, 0, 3, 3, 1'b0, 1'b0);
        checks++;
        if (drop_err !== 1'b1 || vec_count !== 17'(m_vec)) begin
            errors++;
            $display("FAIL drop_in_done got de=%b vec=%0d want de=1 vec=%0d", drop_err, vec_count, m_vec);
        end
    endtask

    task automatic test_arm_capture;
        arm_and_clear();
        checks++;
        if ({coord_err, drop_err} !== 2'b00) begin
            errors++;
            $display("FAIL arm_clears_flags got %b want 00", {coord_err, drop_err});
        end
        for (int i = 0; i < 5; i++) send_beat(i, i % H, 40 + i, -40 - i, 1'b0, 1'b1);
        checks++;
        if (vec_count !== 17'd5) begin
            errors++;
            $display("FAIL capture_five got %0d want 5", vec_count);
        end
        // arm coincident with a beat: arm wins and the beat is dropped silently.
        bus.flow_valid = 1'b1;
        bus.flow_x     = 10'd7;
        bus.flow_y     = 9'd3;
        bus.flow_u     = 16'sd1;
        bus.flow_v     = 16'sd1;
        arm            = 1'b1;
        tick;
        arm            = 1'b0;
        bus.flow_valid = 1'b0;
        model_reset();
        checks++;
        if ({vec_count, moving_count} !== 34'd0 || {sum_u, sum_v} !== 64'd0) begin
            errors++;
            $display("FAIL rearm_stats got vec=%0d mov=%0d su=%0d sv=%0d want 0",
                     vec_count, moving_count, sum_u, sum_v);
        end
        checks++;
        if ({capture_busy, coord_err, drop_err} !== 3'b100) begin
            errors++;
            $display("FAIL rearm_flags got %b want 100", {capture_busy, coord_err, drop_err});
        end
        repeat (DEPTH) tick;
        for (int i = 0; i < 6; i++) begin
            int a;
            a = (i < 5) ? ((i % H) * W + i) : (3 * W + 7);
            issue_read(a);
            checks++;
            begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (bus.rd_valid !== 1'b1 || bus.rd_data !== e) begin
                    errors++;
                    $display("FAIL reclear_read addr=%0d got v=%b d=%h want v=1 d=%h",
                             a, bus.rd_valid, bus.rd_data, e);
                end
            end
        end
    endtask

    task automatic test_rst_mid_clear;
        arm = 1'b1;
        tick;
        arm = 1'b0;
        model_reset();
        repeat (10) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        checks++;
        if ({capture_busy, capture_done, bus.rd_valid, coord_err, drop_err} !== 5'b0 ||
            {vec_count, moving_count} !== 34'd0) begin
            errors++;
            $display("FAIL rst_mid_clear got busy=%b done=%b rv=%b vec=%0d want 0",
                     capture_busy, capture_done, bus.rd_valid, vec_count);
        end
        issue_read(3);
        checks++;
        begin
            logic [31:0] e;
            e = exp_q.pop_front();
            if (bus.rd_valid !== 1'b1 || bus.rd_data !== e) begin
                errors++;
                $display("FAIL idle_read got v=%b d=%h want v=1 d=%h", bus.rd_valid, bus.rd_data, e);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        model_reset();
        test_reset();
        test_clear();
        test_stream();
        test_magnitude();
        test_errors();
        test_arm_capture();
        test_rst_mid_clear();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got %0d entries want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
